// File: rtl/ss_debounce_if.sv
// Debouncer signal bundle: raw level in, debounced level and busy flag out.
// The producer side (pushbutton pad / testbench) uses master, the debouncer uses slave.
interface ss_debounce_if;
    logic i_signal;
    logic o_signal;
    logic o_busy;

    modport master (
        output i_signal,
        input  o_signal,
        input  o_busy
    );

    modport slave (
        input  i_signal,
        output o_signal,
        output o_busy
    );
endinterface

// File: rtl/ss_debounce.sv
// Pushbutton/switch debouncer.
// The raw input is first synchronised through a short flop chain.
// A four-state FSM then qualifies every candidate level change: the new level
// must be sampled DEBOUNCE_CYCLES times in a row before the output follows it.
// Both outputs are registered, so the debounced level can drive an edge
// detector directly.
module ss_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ss_debounce_if.slave bus
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // One-hot encoding, so corrupted values are detectable and fall into the default branch.
    typedef enum logic [3:0] {
        STABLE_LO = 4'b0001,
        WAIT_HI   = 4'b0010,
        STABLE_HI = 4'b0100,
        WAIT_LO   = 4'b1000
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   sig_q;
    logic                   busy_q;

    assign sync         = sync_ff[SYNC_STAGES-1];
    assign bus.o_signal = sig_q;
    assign bus.o_busy   = busy_q;

    // Synchroniser chain: the only logic that ever looks at the raw asynchronous input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_ff <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.i_signal};
        end
    end

    // Qualification FSM; count, output level and busy flag all change alongside the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= RESET_STATE;
            cnt    <= '0;
            sig_q  <= RESET_LEVEL;
            busy_q <= 1'b0;
        end else begin
            case (state)
                STABLE_LO: begin
                    if (sync) begin
                        state  <= WAIT_HI;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end
                end
                WAIT_HI: begin
                    if (!sync) begin
                        state  <= STABLE_LO;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state  <= STABLE_HI;
                        sig_q  <= 1'b1;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync) begin
                        state  <= WAIT_LO;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end
                end
                WAIT_LO: begin
                    if (sync) begin
                        state  <= STABLE_HI;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state  <= STABLE_LO;
                        sig_q  <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state  <= sig_q ? STABLE_HI : STABLE_LO;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ss_debounce.sv
// Self-checking bench for ss_debounce (2 sync stages, 4 debounce cycles).
// dut0 uses reset level 0 and carries most of the checks; dut1 uses reset
// level 1 with its input held high.
module tb_ss_debounce;

    localparam int SYNC_STAGES = 2;
    localparam int DC          = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst1;

    int tests_run    = 0;
    int tests_failed = 0;

    ss_debounce_if bus0();
    ss_debounce_if bus1();

    ss_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (1'b0)
    ) dut0 (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus0)
    );

    ss_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (1'b1)
    ) dut1 (
        .i_clk(clk),
        .i_rst(rst1),
        .bus  (bus1)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference model: the FSM sees the raw level SYNC_STAGES edges late, and the
    // output flips once the last DC seen samples all differ from it.
    bit m_pipe[$];
    bit m_hist[$];
    bit m_o;
    bit m_busy;

    typedef struct {
        bit do_reset;
        bit raw;
        bit exp_o;
        bit exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic modelReset();
        m_pipe.delete();
        m_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
        m_o    = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic modelStep(input bit raw);
        bit seen;
        bit all_diff;
        seen = m_pipe.pop_front();
        m_pipe.push_back(raw);
        m_hist.push_back(seen);
        if (m_hist.size() > DC) void'(m_hist.pop_front());
        all_diff = (m_hist.size() == DC);
        foreach (m_hist[i]) if (m_hist[i] == m_o) all_diff = 1'b0;
        if (all_diff) m_o = ~m_o;
        m_busy = (seen != m_o);
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input bit exp_o, input bit exp_busy);
        checkBit({name, ".o_signal"}, bus0.o_signal, exp_o);
        checkBit({name, ".o_busy"}, bus0.o_busy, exp_busy);
    endtask

    // Called at a falling edge: drive, let one rising edge happen, return at the next falling edge.
    task automatic applyStimulus(input bit raw);
        bus0.i_signal = raw;
        @(posedge clk);
        modelStep(raw);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic addVec(input bit r, input bit raw, input bit eo, input bit eb);
        vec_t v;
        v.do_reset = r;
        v.raw      = raw;
        v.exp_o    = eo;
        v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int  rise_edge;
        bit  seen_busy;
        bit  level;
        int  hold;
        int  last_toggle;
        logic prev_o;

        rst  = 1'b1;
        rst1 = 1'b1;
        bus0.i_signal = 1'b0;
        bus1.i_signal = 1'b1;
        modelReset();

        // Clean rise then clean fall, output changes after edges 6 and 14.
        addVec(1, 1, 0, 0); addVec(0, 1, 0, 0); addVec(0, 1, 0, 1); addVec(0, 1, 0, 1);
        addVec(0, 1, 0, 1); addVec(0, 1, 1, 0); addVec(0, 1, 1, 0); addVec(0, 1, 1, 0);
        addVec(0, 0, 1, 0); addVec(0, 0, 1, 0); addVec(0, 0, 1, 1); addVec(0, 0, 1, 1);
        addVec(0, 0, 1, 1); addVec(0, 0, 0, 0); addVec(0, 0, 0, 0); addVec(0, 0, 0, 0);
        // Bounce 1,0,1,1,0,1 then held high: single rise after edge 11.
        addVec(1, 1, 0, 0); addVec(0, 0, 0, 0); addVec(0, 1, 0, 1); addVec(0, 1, 0, 0);
        addVec(0, 0, 0, 1); addVec(0, 1, 0, 1); addVec(0, 1, 0, 0); addVec(0, 1, 0, 1);
        addVec(0, 1, 0, 1); addVec(0, 1, 0, 1); addVec(0, 1, 1, 0); addVec(0, 1, 1, 0);

        #1;
        checkOutput("reset_async", 1'b0, 1'b0);
        checkBit("rl1_reset.o_signal", bus1.o_signal, 1'b1);
        checkBit("rl1_reset.o_busy", bus1.o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) doReset();
            applyStimulus(vecs[i].raw);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_busy);
        end

        $display("[TB] short glitch while high");
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1);
        checkOutput("glitch_setup", 1'b1, 1'b0);
        seen_busy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus((i < 3) ? 1'b0 : 1'b1);
            if (bus0.o_busy === 1'b1) seen_busy = 1'b1;
            checkOutput($sformatf("glitch%0d", i), 1'b1, m_busy);
        end
        checkBit("glitch_busy_pulsed", seen_busy, 1'b1);

        $display("[TB] reset during qualification");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
        checkOutput("midqual_before_rst", 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midqual_async_rst", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        rise_edge = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1);
            if (bus0.o_signal === 1'b1 && rise_edge == 0) rise_edge = k;
        end
        checkInt("midqual_rise_edge", rise_edge, SYNC_STAGES + DC);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("high_async_rst", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();

        $display("[TB] reset level 1 with input held high");
        rst1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkBit($sformatf("rl1_%0d.o_signal", i), bus1.o_signal, 1'b1);
            checkBit($sformatf("rl1_%0d.o_busy", i), bus1.o_busy, 1'b0);
        end

        $display("[TB] random bouncing input");
        doReset();
        level       = 1'b0;
        hold        = 0;
        last_toggle = -100;
        prev_o      = bus0.o_signal;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                level = 1'($urandom_range(0, 1));
                hold  = int'($urandom_range(1, 7));
            end
            hold--;
            applyStimulus(level);
            checkOutput($sformatf("rand%0d", c), m_o, m_busy);
            if (bus0.o_signal !== prev_o) begin
                checkBit($sformatf("rand%0d.toggle_spacing", c), logic'((c - last_toggle) >= DC), 1'b1);
                last_toggle = c;
                prev_o      = bus0.o_signal;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
